// File: rtl/exec_dispatch.sv
// exec_dispatch: sits between decode and the execute units.
//   - Holds one command in OUT, which is presented to execute, and one more
//     in SKID, which absorbs a command when OUT cannot move.
//   - After a MUL/IMUL or DIV/IDIV issues, further issue is held off for
//     MUL_LAT or DIV_LAT cycles by a 4-bit stall counter.
//     Commands can still be loaded into OUT and SKID during the stall.
//
// Ports:
//   clk, rst_n             clock and async active-low reset
//   flush                  synchronous clear of all queued work and the stall
//   in_valid / in_ready    upstream handshake; in_ready is registered
//   in_opc/in_opa/in_opb   upstream command and operands
//   out_valid / out_ready  execute handshake
//   out_opc/out_opa/out_opb  command and operands, driven from OUT
//   busy                   stall counter nonzero
module exec_dispatch #(
    parameter int unsigned MUL_LAT = 3,   // 1..15
    parameter int unsigned DIV_LAT = 8    // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opc,
    input  logic [31:0] in_opa,
    input  logic [31:0] in_opb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opc,
    output logic [31:0] out_opa,
    output logic [31:0] out_opb,
    output logic        busy
);

    // Multi-cycle command codes. These follow the generated command table.
    localparam logic [5:0] CMD_MUL  = 6'h10;
    localparam logic [5:0] CMD_IMUL = 6'h11;
    localparam logic [5:0] CMD_DIV  = 6'h12;
    localparam logic [5:0] CMD_IDIV = 6'h13;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    typedef struct packed {
        logic [5:0]  opc;
        logic [31:0] opa;
        logic [31:0] opb;
    } cmd_t;

    cmd_t       out_q, out_d, skid_q, skid_d, in_cmd;
    logic       out_v_q, out_v_d, skid_v_q, skid_v_d;
    logic       rdy_q, rdy_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept, issue;

    assign in_cmd    = '{opc: in_opc, opa: in_opa, opb: in_opb};
    assign in_ready  = rdy_q;
    assign out_valid = out_v_q & (cnt_q == 4'd0);
    assign out_opc   = out_q.opc;
    assign out_opa   = out_q.opa;
    assign out_opb   = out_q.opb;
    assign busy      = (cnt_q != 4'd0);

    assign accept = in_valid & rdy_q;
    assign issue  = out_valid & out_ready;

    always_comb begin
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;

        if (issue) begin
            // rdy_q is ~skid_v_q, so an accept and a full SKID never occur together.
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                out_d   = in_cmd;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
            // Issue implies the counter is 0, so ALU-class commands leave it at 0.
            case (out_q.opc)
                CMD_MUL, CMD_IMUL: cnt_d = MUL_LAT_C;
                CMD_DIV, CMD_IDIV: cnt_d = DIV_LAT_C;
                default:           cnt_d = cnt_q;
            endcase
        end else begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            if (accept) begin
                if (!out_v_q) begin
                    out_d   = in_cmd;
                    out_v_d = 1'b1;
                end else begin
                    skid_d   = in_cmd;
                    skid_v_d = 1'b1;
                end
            end
        end

        // Flush overrides everything. An issue in this cycle is already
        // consumed downstream, so it is not re-presented.
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
            cnt_d    = 4'd0;
        end

        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
            cnt_q    <= 4'd0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_exec_dispatch.sv
module tb_exec_dispatch;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    localparam logic [5:0] CMD_ADD  = 6'h01;
    localparam logic [5:0] CMD_SUB  = 6'h02;
    localparam logic [5:0] CMD_AND  = 6'h03;
    localparam logic [5:0] CMD_OR   = 6'h04;
    localparam logic [5:0] CMD_XOR  = 6'h05;
    localparam logic [5:0] CMD_MUL  = 6'h10;
    localparam logic [5:0] CMD_IMUL = 6'h11;
    localparam logic [5:0] CMD_DIV  = 6'h12;
    localparam logic [5:0] CMD_IDIV = 6'h13;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [5:0]  in_opc, out_opc;
    logic [31:0] in_opa, in_opb, out_opa, out_opb;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    exec_dispatch #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opc(in_opc), .in_opa(in_opa), .in_opb(in_opb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_opa(out_opa), .out_opb(out_opb),
        .busy(busy)
    );

    // Reference model: an in-order queue of at most two commands, plus a
    // count of cycles remaining before issue is allowed again.
    typedef struct {
        logic [5:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t mq[$];
    int   mstall;

    function automatic int lat_of(logic [5:0] opc);
        if (opc == CMD_MUL || opc == CMD_IMUL) return MUL_LAT;
        if (opc == CMD_DIV || opc == CMD_IDIV) return DIV_LAT;
        return 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic m_reset();
        mq.delete();
        mstall = 0;
    endtask

    task automatic m_update(logic v, logic [5:0] opc, logic [31:0] a, logic [31:0] b,
                            logic ordy, logic fl);
        bit   m_rdy, m_ov, iss, acc;
        cmd_t c;
        m_rdy = (mq.size() < 2);
        m_ov  = (mq.size() > 0) && (mstall == 0);
        if (fl) begin
            m_reset();
            return;
        end
        iss = m_ov && ordy;
        acc = v && m_rdy;
        if (iss) begin
            mstall = lat_of(mq[0].opc);
            void'(mq.pop_front());
        end else if (mstall > 0) begin
            mstall--;
        end
        if (acc) begin
            c.opc = opc; c.a = a; c.b = b;
            mq.push_back(c);
        end
    endtask

    task automatic compare();
        bit ov;
        ov = (mq.size() > 0) && (mstall == 0);
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("busy", 32'(busy), 32'(mstall != 0));
        if (ov) begin
            chk("out_opc", 32'(out_opc), 32'(mq[0].opc));
            chk("out_opa", out_opa, mq[0].a);
            chk("out_opb", out_opb, mq[0].b);
        end
    endtask

    // Called at a falling edge: drive, update the model, move to the next
    // falling edge, and check the DUT against the model.
    task automatic step(logic v, logic [5:0] opc, logic [31:0] a, logic [31:0] b,
                        logic ordy, logic fl);
        in_valid = v; in_opc = opc; in_opa = a; in_opb = b;
        out_ready = ordy; flush = fl;
        m_update(v, opc, a, b, ordy, fl);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(logic ordy);
        step(1'b0, 6'h0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        logic [5:0] ops [9];
        ops = '{CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_XOR,
                CMD_MUL, CMD_IMUL, CMD_DIV, CMD_IDIV};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opc = '0; in_opa = '0; in_opb = '0;
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_opc", 32'(out_opc), 32'd0);
        chk("rst out_opa", out_opa, 32'd0);
        chk("rst out_opb", out_opb, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        compare();

        // ALU stream at full throughput
        step(1'b1, CMD_ADD, 32'd1, 32'd0, 1'b1, 1'b0);
        chk("stream v1", 32'(out_valid), 32'd1); chk("stream opa1", out_opa, 32'd1);
        step(1'b1, CMD_XOR, 32'd2, 32'd0, 1'b1, 1'b0);
        chk("stream v2", 32'(out_valid), 32'd1); chk("stream opa2", out_opa, 32'd2);
        chk("stream busy", 32'(busy), 32'd0);
        step(1'b1, CMD_AND, 32'd3, 32'd0, 1'b1, 1'b0);
        chk("stream v3", 32'(out_valid), 32'd1); chk("stream opa3", out_opa, 32'd3);
        idle(1'b1);
        chk("stream drained", 32'(out_valid), 32'd0);

        // MUL, then ADD queued behind it: ADD issues 4 cycles after MUL
        step(1'b1, CMD_MUL, 32'd5, 32'd6, 1'b1, 1'b0);
        chk("mul present", 32'(out_opc), 32'(CMD_MUL));
        step(1'b1, CMD_ADD, 32'd7, 32'd8, 1'b1, 1'b0);   // MUL issues here (T)
        chk("mul T+1 busy", 32'(busy), 32'd1);
        chk("mul T+1 ov", 32'(out_valid), 32'd0);
        chk("mul T+1 rdy", 32'(in_ready), 32'd1);
        idle(1'b1);
        chk("mul T+2 busy", 32'(busy), 32'd1);
        idle(1'b1);
        chk("mul T+3 busy", 32'(busy), 32'd1);
        chk("mul T+3 rdy", 32'(in_ready), 32'd1);
        idle(1'b1);
        chk("mul T+4 busy", 32'(busy), 32'd0);
        chk("mul T+4 ov", 32'(out_valid), 32'd1);
        chk("mul T+4 opa", out_opa, 32'd7);
        idle(1'b1);

        // Backpressure: OUT and SKID fill, the third command waits
        step(1'b1, CMD_ADD, 32'd10, 32'd0, 1'b0, 1'b0);
        chk("bp rdy1", 32'(in_ready), 32'd1);
        step(1'b1, CMD_SUB, 32'd11, 32'd0, 1'b0, 1'b0);
        chk("bp rdy2", 32'(in_ready), 32'd0);
        step(1'b1, CMD_OR, 32'd12, 32'd0, 1'b0, 1'b0);
        chk("bp hold", out_opa, 32'd10);
        step(1'b1, CMD_OR, 32'd12, 32'd0, 1'b1, 1'b0);
        chk("bp second", out_opa, 32'd11); chk("bp rdy3", 32'(in_ready), 32'd1);
        step(1'b1, CMD_OR, 32'd12, 32'd0, 1'b1, 1'b0);
        chk("bp third", out_opa, 32'd12);
        idle(1'b1);
        chk("bp drained", 32'(out_valid), 32'd0);

        // DIV issued, both registers filled during the stall, then flush
        step(1'b1, CMD_DIV, 32'd20, 32'd4, 1'b1, 1'b0);
        step(1'b1, CMD_ADD, 32'd21, 32'd0, 1'b1, 1'b0);
        step(1'b1, CMD_SUB, 32'd22, 32'd0, 1'b1, 1'b0);
        chk("div full rdy", 32'(in_ready), 32'd0);
        chk("div busy", 32'(busy), 32'd1);
        step(1'b1, CMD_XOR, 32'd23, 32'd0, 1'b1, 1'b1);
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush ov", 32'(out_valid), 32'd0);
        chk("flush rdy", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a DIV stall with both full
        step(1'b1, CMD_DIV, 32'd30, 32'd4, 1'b1, 1'b0);
        step(1'b1, CMD_ADD, 32'd31, 32'd0, 1'b1, 1'b0);
        step(1'b1, CMD_SUB, 32'd32, 32'd0, 1'b1, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst ov", 32'(out_valid), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst rdy", 32'(in_ready), 32'd1);
        chk("arst opc", 32'(out_opc), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, CMD_OR, 32'h99, 32'h5, 1'b0, 1'b0);
        chk("post-rst ov", 32'(out_valid), 32'd1);
        chk("post-rst opc", 32'(out_opc), 32'(CMD_OR));
        chk("post-rst opa", out_opa, 32'h99);
        idle(1'b1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 8)], $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
